// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// The winner's request is captured at grant, then held for LAT access cycles and one done/ack cycle.
module dmem_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             owner;
  logic             we_q;

  logic             any_req_c;
  logic             win_c;
  logic             win_we_c;
  logic [31:0]      win_addr_c;
  logic [31:0]      win_wdata_c;

  // Round-robin pick: on contention the port that was not served last wins.
  assign any_req_c   = req0_i | req1_i;
  assign win_c       = (req0_i & req1_i) ? ~last : req1_i;
  assign win_we_c    = win_c ? we1_i    : we0_i;
  assign win_addr_c  = win_c ? addr1_i  : addr0_i;
  assign win_wdata_c = win_c ? wdata1_i : wdata0_i;

  // FSM with registered outputs; memory side is driven only from values captured at grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= 1'b1;
      owner       <= 1'b0;
      we_q        <= 1'b0;
      gnt0_o      <= 1'b0;
      gnt1_o      <= 1'b0;
      ack0_o      <= 1'b0;
      ack1_o      <= 1'b0;
      rdata_o     <= '0;
      busy_o      <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
      mem_re_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req_c) begin
            state       <= ACCESS;
            cnt         <= CNT_W'(1);
            last        <= win_c;
            owner       <= win_c;
            we_q        <= win_we_c;
            mem_addr_o  <= win_addr_c;
            mem_wdata_o <= win_wdata_c;
            mem_we_o    <= win_we_c;
            mem_re_o    <= ~win_we_c;
            gnt0_o      <= ~win_c;
            gnt1_o      <= win_c;
            busy_o      <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == CNT_W'(LAT)) begin
            state    <= DONE;
            cnt      <= '0;
            mem_we_o <= 1'b0;
            mem_re_o <= 1'b0;
            ack0_o   <= ~owner;
            ack1_o   <= owner;
            if (!we_q) begin
              rdata_o <= mem_rdata_i;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          gnt0_o <= 1'b0;
          gnt1_o <= 1'b0;
          ack0_o <= 1'b0;
          ack1_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
